// File: rtl/fetch_unit_pkg.sv
// Shared fetch types: the {pc, instr} packet handed to decode
// and the fetch address helpers.
package fetch_unit_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          INSTR_BYTES      = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_pkt_t;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Instruction buffer: registered sync FIFO of fetch packets.
// Flush wins over push and pop in the same cycle.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_pkt_t    wdata,
  output fetch_pkt_t    rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  fetch_pkt_t        mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;

  assign rdata = mem[rd_ptr];
  assign count = cnt;
  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: issues imem word reads under a credit limit,
// buffers responses, and squashes stale ones after a redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_mem_req_valid,
  output logic [31:0] o_mem_req_addr,
  input  logic        i_mem_req_ready,
  input  logic        i_mem_resp_valid,
  input  logic [31:0] i_mem_resp_data,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  input  logic        i_ready,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0] fetch_pc;
  logic [31:0] resp_pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   used;
  logic          run;
  logic          accept;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  fetch_pkt_t    head;
  fetch_pkt_t    pkt;

  assign pop  = o_valid && i_ready && !i_redirect;
  assign push = i_mem_resp_valid && (drop_cnt == '0)
             && !i_redirect;

  // A pop this cycle frees a slot, so it counts as credit.
  assign used = {1'b0, inflight} + {1'b0, fifo_count}
              - (CW+1)'(pop);

  assign o_mem_req_valid = run && !i_redirect
                        && (used < (CW+1)'(FIFO_DEPTH));
  assign o_mem_req_addr  = fetch_pc;
  assign accept = o_mem_req_valid && i_mem_req_ready;

  assign pkt.pc    = resp_pc;
  assign pkt.instr = i_mem_resp_data;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (push),
    .pop   (pop),
    .flush (i_redirect),
    .wdata (pkt),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign o_valid = !empty;
  assign o_instr = head.instr;
  assign o_pc    = head.pc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      run      <= 1'b0;
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      run <= 1'b1;
      assert (!(i_mem_resp_valid && inflight == '0));
      assert (!(push && full && !pop));
      assert (inflight <= CW'(FIFO_DEPTH));
      if (i_redirect) begin
        assert (i_redirect_pc[1:0] == 2'b00);
        fetch_pc <= word_align(i_redirect_pc);
        resp_pc  <= word_align(i_redirect_pc);
        // Every outstanding response is now stale,
        // including ones already marked for drop.
        inflight <= inflight - CW'(i_mem_resp_valid);
        drop_cnt <= inflight - CW'(i_mem_resp_valid);
      end else begin
        if (accept) begin
          fetch_pc <= fetch_pc + 32'(INSTR_BYTES);
        end
        if (push) begin
          resp_pc <= resp_pc + 32'(INSTR_BYTES);
        end
        inflight <= inflight + CW'(accept)
                  - CW'(i_mem_resp_valid);
        if (i_mem_resp_valid && drop_cnt != '0) begin
          drop_cnt <= drop_cnt - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queued imem model with variable latency,
// directed scenarios, then random traffic against a pc-stream model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  int checks;
  int failures;
  int req_cnt;
  int pop_cnt;
  int mlat;
  int mcyc;
  logic [31:0] exp_pc;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];

  fetch_unit #(
    .RESET_PC   (32'h0),
    .FIFO_DEPTH (2)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .o_mem_req_valid  (mem_req_valid),
    .o_mem_req_addr   (mem_req_addr),
    .i_mem_req_ready  (mem_req_ready),
    .i_mem_resp_valid (mem_resp_valid),
    .i_mem_resp_data  (mem_resp_data),
    .o_valid          (valid),
    .o_instr          (instr),
    .o_pc             (pc),
    .i_ready          (ready),
    .i_redirect       (redirect),
    .i_redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // In-order memory: response due mlat cycles after accept.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mcyc = 0;
      mem_resp_valid <= 1'b0;
      mem_resp_data  <= '0;
    end else begin
      mcyc++;
      if (mem_req_valid && mem_req_ready) begin
        mq.push_back('{addr: mem_req_addr, due: mcyc + mlat - 1});
        req_cnt++;
      end
      mem_resp_valid <= 1'b0;
      if (mq.size() > 0 && mq[0].due <= mcyc) begin
        mem_resp_valid <= 1'b1;
        mem_resp_data  <= memf(mq[0].addr);
        void'(mq.pop_front());
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with inputs driven; checks consumption.
  task automatic step();
    #1;
    if (redirect) begin
      exp_pc = redirect_pc;
    end else if (valid && ready) begin
      chk("stream_pc", pc, exp_pc);
      chk("stream_instr", instr, memf(exp_pc));
      exp_pc  = exp_pc + 32'd4;
      pop_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic do_redirect(input logic [31:0] t);
    redirect    = 1'b1;
    redirect_pc = t;
    step();
    redirect    = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    bit found;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (valid) found = 1;
      else step();
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  initial begin
    int base;
    bit found;
    logic [31:0] r;
    checks = 0; failures = 0;
    req_cnt = 0; pop_cnt = 0;
    mlat = 1;
    rst_n = 1'b0;
    mem_req_ready = 1'b1;
    ready = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;
    exp_pc = 32'h0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_req_addr", mem_req_addr, 32'h0);

    // 1: latency and sequential stream after reset
    rst_n = 1'b1;
    step();
    chk("t1_lat1", 32'(valid), 32'd0);
    step();
    chk("t1_lat2", 32'(valid), 32'd0);
    step();
    chk("t1_lat3", 32'(valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("t1_seq_valid", 32'(valid), 32'd1);
      chk("t1_seq_pc", pc, 32'(4 * i));
      chk("t1_seq_instr", instr, memf(32'(4 * i)));
      step();
    end

    // 2: decode stall fills the buffer then fetch stops
    ready = 1'b0;
    do_redirect(32'h40);
    base = req_cnt;
    repeat (10) step();
    chk("t2_reqs", 32'(req_cnt - base), 32'd2);
    chk("t2_valid", 32'(valid), 32'd1);
    chk("t2_pc", pc, 32'h40);
    chk("t2_req_stop", 32'(mem_req_valid), 32'd0);
    ready = 1'b1;
    base = pop_cnt;
    repeat (8) step();
    chk("t2_no_gap", 32'(pop_cnt - base), 32'd8);

    // 3: redirect with two requests in flight
    mlat = 3;
    do_redirect(32'h80);
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (mq.size() == 2 && !mem_resp_valid) found = 1;
      else step();
    end
    chk("t3_two_inflight", 32'(found), 32'd1);
    do_redirect(32'h100);
    wait_valid("t3_wait");
    chk("t3_pc", pc, 32'h100);
    chk("t3_instr", instr, memf(32'h100));
    repeat (6) step();

    // 4: redirect coincident with response and pop
    mlat = 2;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (mem_resp_valid && valid) found = 1;
      else step();
    end
    chk("t4_coincide", 32'(found), 32'd1);
    do_redirect(32'h200);
    chk("t4_empty", 32'(valid), 32'd0);
    wait_valid("t4_wait");
    chk("t4_pc", pc, 32'h200);
    chk("t4_instr", instr, memf(32'h200));
    repeat (4) step();

    // 5: memory backpressure and fetch_pc wrap
    mlat = 1;
    mem_req_ready = 1'b0;
    do_redirect(32'hFFFF_FFFC);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_valid", 32'(mem_req_valid), 32'd1);
      chk("t5_hold_addr", mem_req_addr, 32'hFFFF_FFFC);
      step();
    end
    mem_req_ready = 1'b1;
    step();
    chk("t5_wrap_addr", mem_req_addr, 32'h0);
    wait_valid("t5_wait");
    chk("t5_pc_last", pc, 32'hFFFF_FFFC);
    step();
    chk("t5_wrap_valid", 32'(valid), 32'd1);
    chk("t5_wrap_pc", pc, 32'h0);
    repeat (4) step();

    // 6: reset mid-stream
    rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(valid), 32'd0);
    chk("t6_req_valid", 32'(mem_req_valid), 32'd0);
    chk("t6_pc", pc, 32'h0);
    exp_pc = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("t6_req_valid2", 32'(mem_req_valid), 32'd1);
    chk("t6_req_addr", mem_req_addr, 32'h0);
    wait_valid("t6_wait");
    chk("t6_first_pc", pc, 32'h0);

    // Random traffic, checked by the pc-stream model in step()
    mlat = 2;
    base = pop_cnt;
    for (int i = 0; i < 400; i++) begin
      ready = ($urandom_range(0, 3) != 0);
      mem_req_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        r = $urandom;
        r[1:0] = 2'b00;
        do_redirect(r);
      end else begin
        step();
      end
      if (i == 200) mlat = 1;
    end
    chk("rand_progress", 32'(pop_cnt - base > 50), 32'd1);
    chk("addr_aligned", 32'(mem_req_addr[1:0]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
